mmu_mem_bridge: RTL and testbench

- Sits directly downstream of the serial-load MMU (SPART plus driver).
- Consumes the MMU's single-cycle memory-port-B strobes (enb/web/addrb/dinb/flsh) and buffers writes in a small FIFO.
- Replays buffered writes and reads to the memory system over a req/ack handshake.
- Returns read data (doutb) and the flush-complete pulse (mem_sys_fin) to the MMU, and stalls the CPU while a program load is in progress.

---
 rtl/mmu_pkg.sv | 26 ++
 rtl/mmu_wr_fifo.sv | 63 ++++++
 rtl/mmu_mem_bridge.sv | 196 +++++++++++++++++++
 tb/tb_mmu_mem_bridge.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// ---------------------------------------------------------------------------
// mmu_pkg
// Shared definitions for the MMU-to-memory bridge: default widths, FIFO depth
// and the bridge FSM state encoding, plus a small decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mmu_pkg;

  localparam int ADDR_W_DEF     = 14;
  localparam int DATA_W_DEF     = 64;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_REQ  = 3'd2,
    READ_WAIT = 3'd3,
    FIN       = 3'd4
  } state_t;

  // States in which a request is presented to the memory system.
  function automatic logic state_has_req(input state_t s);
    return (s == WRITE) || (s == READ_REQ);
  endfunction

endpackage

// File: rtl/mmu_wr_fifo.sv
// ---------------------------------------------------------------------------
// mmu_wr_fifo
// Synchronous write-buffer FIFO. Pointers carry one extra wrap bit so that
// full/empty are told apart by comparing the MSBs. The head entry is shown
// combinationally on dout whenever the FIFO is not empty.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push, din   write an entry (ignored when full unless popping the same cycle)
//   pop         remove the head entry (ignored when empty)
//   dout        head entry
//   full, empty status flags
// ---------------------------------------------------------------------------
module mmu_wr_fifo #(
  parameter int WIDTH = 78,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage; cleared on reset so stale data never reaches the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/mmu_mem_bridge.sv
// ---------------------------------------------------------------------------
// mmu_mem_bridge
// Converts the MMU's single-cycle port-B strobes into a req/ack memory
// transaction stream. Writes are buffered in a small FIFO; one read and one
// flush may be pending. Buffered writes always go out before a pending read
// (read-after-write safe) and before the flush-complete pulse.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   enb, web, addrb, dinb  MMU port strobe (web=1 write, 0 read)
//   flsh                   MMU flush request strobe
//   doutb                  last read data returned by memory
//   mem_sys_fin            one-cycle flush-complete pulse
//   mem_req/we/addr/wdata  memory request, held until mem_ack
//   mem_ack                memory accepted the request
//   mem_rvalid, mem_rdata  read data return
//   cpu_stall              CPU hold while a program load is in flight
//   ovf_err                sticky: a write was dropped on a full FIFO
// All outputs are registers.
// ---------------------------------------------------------------------------
module mmu_mem_bridge
  import mmu_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  input  logic              flsh,
  output logic [DATA_W-1:0] doutb,
  output logic              mem_sys_fin,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall,
  output logic              ovf_err
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  state_t              state;
  state_t              next_state;
  logic                wr_strobe;
  logic                rd_strobe;
  logic                pop;
  logic                push_ok;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_head;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic                rd_pend;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   rd_addr_nxt;
  logic                fl_pend;

  assign wr_strobe   = enb & web;
  assign rd_strobe   = enb & ~web;
  assign pop         = (state == WRITE) & mem_ack;
  assign push_ok     = wr_strobe & (~fifo_full | pop);
  assign drop        = wr_strobe & fifo_full & ~pop;
  assign head_addr   = fifo_head[ENTRY_W-1:DATA_W];
  assign head_data   = fifo_head[DATA_W-1:0];
  // Address the read will carry after this edge (a newer read overwrites).
  assign rd_addr_nxt = rd_strobe ? addrb : rd_addr;

  mmu_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .din   ({addrb, dinb}),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode; IDLE arbitrates writes, then read, then flush.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!fifo_empty)  next_state = WRITE;
        else if (rd_pend) next_state = READ_REQ;
        else if (fl_pend) next_state = FIN;
        else              next_state = IDLE;
      end
      WRITE: begin
        if (mem_ack) next_state = IDLE;
        else         next_state = WRITE;
      end
      READ_REQ: begin
        if (mem_ack) next_state = READ_WAIT;
        else         next_state = READ_REQ;
      end
      READ_WAIT: begin
        if (mem_rvalid) next_state = IDLE;
        else            next_state = READ_WAIT;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pending read tracking; a read strobe on the ack cycle keeps it pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_addr <= '0;
    end else if (rd_strobe) begin
      rd_pend <= 1'b1;
      rd_addr <= addrb;
    end else if ((state == READ_REQ) && mem_ack) begin
      rd_pend <= 1'b0;
    end
  end

  // Pending flush; a flush arriving during FIN re-arms for a second pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                fl_pend <= 1'b0;
    else if (flsh)          fl_pend <= 1'b1;
    else if (state == FIN)  fl_pend <= 1'b0;
  end

  // Memory-side request outputs, registered from the upcoming state so they
  // line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req <= state_has_req(next_state);
      mem_we  <= (next_state == WRITE);
      case (next_state)
        WRITE: begin
          mem_addr  <= head_addr;
          mem_wdata <= head_data;
        end
        READ_REQ: begin
          mem_addr  <= rd_addr_nxt;
          mem_wdata <= '0;
        end
        default: begin
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
      endcase
    end
  end

  // Read data return, captured only while waiting for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   doutb <= '0;
    else if ((state == READ_WAIT) && mem_rvalid) doutb <= mem_rdata;
  end

  // Flush-complete pulse, high for the single FIN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_sys_fin <= 1'b0;
    else     mem_sys_fin <= (next_state == FIN);
  end

  // CPU stall: raised by accepted writes, released right after the FIN pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cpu_stall <= 1'b0;
    else if (push_ok)       cpu_stall <= 1'b1;
    else if (state == FIN)  cpu_stall <= 1'b0;
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ovf_err <= 1'b0;
    else if (drop) ovf_err <= 1'b1;
  end

endmodule

// File: tb/tb_mmu_mem_bridge.sv
module tb_mmu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enb = 1'b0;
  logic        web = 1'b0;
  logic [13:0] addrb = '0;
  logic [63:0] dinb = '0;
  logic        flsh = 1'b0;
  logic [63:0] doutb;
  logic        mem_sys_fin;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        cpu_stall;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;

  mmu_mem_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .web         (web),
    .addrb       (addrb),
    .dinb        (dinb),
    .flsh        (flsh),
    .doutb       (doutb),
    .mem_sys_fin (mem_sys_fin),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .cpu_stall   (cpu_stall),
    .ovf_err     (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    assert (mem_req === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed no mem_req expected mem_req within 20 cycles", tag);
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [63:0] d);
    enb = 1'b1; web = 1'b1; addrb = a; dinb = d;
  endtask

  task automatic idle_in();
    enb = 1'b0; web = 1'b0; flsh = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    #1 rst = 1'b1;
    step(); step();
    chk("rst_req",   {63'd0, mem_req},     64'd0);
    chk("rst_fin",   {63'd0, mem_sys_fin}, 64'd0);
    chk("rst_stall", {63'd0, cpu_stall},   64'd0);
    chk("rst_ovf",   {63'd0, ovf_err},     64'd0);
    chk("rst_doutb", doutb,                64'd0);
    rst = 1'b0;
    step();

    // ---------------- single write ----------------
    wr(14'h0012, 64'hDEADBEEF_00000001);
    step(); idle_in();
    chk("wr1_req_lat1", {63'd0, mem_req},   64'd0);
    chk("wr1_stall",    {63'd0, cpu_stall}, 64'd1);
    step();
    chk("wr1_req_lat2", {63'd0, mem_req},   64'd1);
    chk("wr1_we",       {63'd0, mem_we},    64'd1);
    chk("wr1_addr",     {50'd0, mem_addr},  64'h12);
    chk("wr1_data",     mem_wdata,          64'hDEADBEEF_00000001);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    chk("wr1_req_drop", {63'd0, mem_req},   64'd0);

    // ---------------- flush with empty FIFO ----------------
    flsh = 1'b1;
    step(); flsh = 1'b0;
    chk("fl0_fin_c1",   {63'd0, mem_sys_fin}, 64'd0);
    step();
    chk("fl0_fin_c2",   {63'd0, mem_sys_fin}, 64'd1);
    chk("fl0_stall_on", {63'd0, cpu_stall},   64'd1);
    step();
    chk("fl0_fin_c3",    {63'd0, mem_sys_fin}, 64'd0);
    chk("fl0_stall_off", {63'd0, cpu_stall},   64'd0);

    // ---------------- overflow ----------------
    for (int i = 0; i < 4; i++) begin
      wr(14'h0100 + 14'(i), 64'h1000 + 64'(i));
      step();
    end
    chk("ovf_before", {63'd0, ovf_err}, 64'd0);
    wr(14'h0104, 64'h1004);
    step(); idle_in();
    chk("ovf_set", {63'd0, ovf_err}, 64'd1);
    for (int i = 0; i < 6; i++) step();
    chk("ovf_hold_req",  {63'd0, mem_req},  64'd1);
    chk("ovf_hold_addr", {50'd0, mem_addr}, 64'h100);
    for (int i = 0; i < 4; i++) begin
      wait_req("ovf_drain_req");
      chk("ovf_drain_addr", {50'd0, mem_addr}, 64'h100 + 64'(i));
      chk("ovf_drain_data", mem_wdata,         64'h1000 + 64'(i));
      mem_ack = 1'b1;
      step(); mem_ack = 1'b0;
      chk("ovf_drain_gap", {63'd0, mem_req}, 64'd0);
    end
    step(); step(); step();
    chk("ovf_fifth_dropped", {63'd0, mem_req}, 64'd0);
    chk("ovf_sticky",        {63'd0, ovf_err}, 64'd1);

    // ---------------- read after write ----------------
    wr(14'h0003, 64'hA5);
    step();
    enb = 1'b1; web = 1'b0; addrb = 14'h0003;
    step(); idle_in();
    chk("raw_w_req",  {63'd0, mem_req},  64'd1);
    chk("raw_w_we",   {63'd0, mem_we},   64'd1);
    chk("raw_w_addr", {50'd0, mem_addr}, 64'h3);
    chk("raw_w_data", mem_wdata,         64'hA5);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    chk("raw_gap", {63'd0, mem_req}, 64'd0);
    step();
    chk("raw_r_req",  {63'd0, mem_req},  64'd1);
    chk("raw_r_we",   {63'd0, mem_we},   64'd0);
    chk("raw_r_addr", {50'd0, mem_addr}, 64'h3);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    chk("raw_r_wait", {63'd0, mem_req}, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'hA5;
    step(); mem_rvalid = 1'b0; mem_rdata = 64'hFFFF;
    chk("raw_doutb", doutb, 64'hA5);
    mem_rvalid = 1'b1; mem_rdata = 64'h77;
    step(); mem_rvalid = 1'b0;
    chk("raw_rvalid_ignored", doutb, 64'hA5);

    // ---------------- three writes then flush ----------------
    wr(14'h0200, 64'h2000); step();
    wr(14'h0201, 64'h2001); step();
    wr(14'h0202, 64'h2002); flsh = 1'b1; step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      wait_req("fl3_req");
      chk("fl3_addr", {50'd0, mem_addr}, 64'h200 + 64'(i));
      chk("fl3_no_fin_early", {63'd0, mem_sys_fin}, 64'd0);
      mem_ack = 1'b1;
      step(); mem_ack = 1'b0;
      chk("fl3_no_fin_ack", {63'd0, mem_sys_fin}, 64'd0);
    end
    step();
    chk("fl3_fin",       {63'd0, mem_sys_fin}, 64'd1);
    chk("fl3_stall_on",  {63'd0, cpu_stall},   64'd1);
    step();
    chk("fl3_fin_off",   {63'd0, mem_sys_fin}, 64'd0);
    chk("fl3_stall_off", {63'd0, cpu_stall},   64'd0);
    step(); step();
    chk("fl3_single_pulse", {63'd0, mem_sys_fin}, 64'd0);

    // ---------------- reset during WRITE ----------------
    wr(14'h0300, 64'h3000); step();
    wr(14'h0301, 64'h3001); step();
    idle_in();
    chk("rstw_req_before", {63'd0, mem_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_req_async", {63'd0, mem_req}, 64'd0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rstw_no_req", {63'd0, mem_req},     64'd0);
      chk("rstw_no_fin", {63'd0, mem_sys_fin}, 64'd0);
    end
    chk("rstw_ovf_clr",   {63'd0, ovf_err},   64'd0);
    chk("rstw_stall_clr", {63'd0, cpu_stall}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
